// File: rtl/operand_fetch.sv
// operand_fetch: RV32I decode/operand-fetch stage with busy scoreboard,
// write-back bypass and a one-entry output register toward execute.
module operand_fetch #(
    parameter int ADW = 5,
    parameter int DPW = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DPW-1:0] in_instr,
    input  logic [DPW-1:0] in_pc,
    output logic [ADW-1:0] addr_1,
    output logic [ADW-1:0] addr_2,
    input  logic [DPW-1:0] rd_1,
    input  logic [DPW-1:0] rd_2,
    input  logic           wb_valid,
    input  logic [ADW-1:0] wb_addr,
    input  logic [DPW-1:0] wb_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DPW-1:0] out_instr,
    output logic [DPW-1:0] out_pc,
    output logic [DPW-1:0] out_op1,
    output logic [DPW-1:0] out_op2,
    output logic [ADW-1:0] out_rd,
    output logic           out_wr,
    output logic [31:0]    stall_cnt
);

    localparam int NREG = 2 ** ADW;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    logic [6:0]     opcode;
    logic [ADW-1:0] rs1;
    logic [ADW-1:0] rs2;
    logic [ADW-1:0] rd;
    logic           uses_rs1;
    logic           uses_rs2;
    logic           writes_rd;

    logic           wb_hit1;
    logic           wb_hit2;
    logic           busy_rs1;
    logic           busy_rs2;
    logic           busy_rd;
    logic           hazard;
    logic           accept;

    logic [DPW-1:0] op1;
    logic [DPW-1:0] op2;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [31:0]     stall_q;
    logic [31:0]     stall_d;

    logic           out_valid_q;
    logic [DPW-1:0] out_instr_q;
    logic [DPW-1:0] out_pc_q;
    logic [DPW-1:0] out_op1_q;
    logic [DPW-1:0] out_op2_q;
    logic [ADW-1:0] out_rd_q;
    logic           out_wr_q;

    assign opcode = in_instr[6:0];
    assign rs1    = ADW'(in_instr[19:15]);
    assign rs2    = ADW'(in_instr[24:20]);
    assign rd     = ADW'(in_instr[11:7]);
    assign addr_1 = rs1;
    assign addr_2 = rs2;

    // Source/destination usage derived from the major opcode.
    always_comb begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = (rd != '0);
        unique case (1'b1)
            (opcode == OP_LUI),
            (opcode == OP_AUIPC),
            (opcode == OP_JAL):   uses_rs1 = 1'b0;
            (opcode == OP_REG):   uses_rs2 = 1'b1;
            (opcode == OP_STORE),
            (opcode == OP_BR): begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b0;
            end
            default: ;
        endcase
    end

    // A write-back this cycle resolves the hazard on its register.
    assign wb_hit1  = wb_valid && (wb_addr == rs1);
    assign wb_hit2  = wb_valid && (wb_addr == rs2);
    assign busy_rs1 = busy_q[rs1] && !wb_hit1;
    assign busy_rs2 = busy_q[rs2] && !wb_hit2;
    assign busy_rd  = busy_q[rd] && !(wb_valid && (wb_addr == rd));

    assign hazard   = (uses_rs1 && busy_rs1)
                    || (uses_rs2 && busy_rs2)
                    || (writes_rd && busy_rd);
    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Operand select: x0/unused gives zero, then bypass, then reg_file.
    always_comb begin
        op1 = rd_1;
        op2 = rd_2;
        if (!uses_rs1 || rs1 == '0) begin
            op1 = '0;
        end else if (wb_hit1) begin
            op1 = wb_data;
        end
        if (!uses_rs2 || rs2 == '0) begin
            op2 = '0;
        end else if (wb_hit2) begin
            op2 = wb_data;
        end
    end

    // Scoreboard next state: clear on write-back, then set on issue.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (accept && writes_rd) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Saturating count of cycles lost to hazards.
    always_comb begin
        stall_d = stall_q;
        if (in_valid && hazard && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stage state: scoreboard, stall counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            stall_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_rd_q    <= '0;
            out_wr_q    <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_instr_q <= in_instr;
                out_pc_q    <= in_pc;
                out_op1_q   <= op1;
                out_op2_q   <= op2;
                out_rd_q    <= rd;
                out_wr_q    <= writes_rd;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign out_op1   = out_op1_q;
    assign out_op2   = out_op2_q;
    assign out_rd    = out_rd_q;
    assign out_wr    = out_wr_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus a randomized run checked
// against a pending-write set model of the stage and its reg_file.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  addr_1;
    logic [4:0]  addr_2;
    logic [31:0] rd_1;
    logic [31:0] rd_2;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_wr;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rf [32];
    bit          pend [32];
    bit          m_valid;
    logic [31:0] m_instr, m_pc, m_op1, m_op2, m_stall;
    logic [4:0]  m_rd;
    bit          m_wr;

    always #5 clk = ~clk;

    assign rd_1 = rf[in_instr[19:15]];
    assign rd_2 = rf[in_instr[24:20]];

    operand_fetch #(.ADW(5), .DPW(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .addr_1(addr_1), .addr_2(addr_2),
        .rd_1(rd_1), .rd_2(rd_2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_wr(out_wr),
        .stall_cnt(stall_cnt)
    );

    function automatic bit reads1(logic [31:0] i);
        return !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
    endfunction

    function automatic bit reads2(logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic bit dest(logic [31:0] i);
        return !(i[6:0] inside {7'h23, 7'h63}) && i[11:7] != 5'd0;
    endfunction

    // A register is still pending unless its write-back lands now.
    function automatic bit waiting(logic [4:0] r);
        return pend[r] && !(wb_valid && wb_addr == r);
    endfunction

    function automatic bit m_hazard(logic [31:0] i);
        return (reads1(i) && waiting(i[19:15]))
            || (reads2(i) && waiting(i[24:20]))
            || (dest(i) && waiting(i[11:7]));
    endfunction

    function automatic bit m_ready(logic [31:0] i);
        return (!m_valid || out_ready) && !m_hazard(i);
    endfunction

    function automatic logic [31:0] src_val(bit used, logic [4:0] r);
        if (!used || r == 5'd0) return 32'd0;
        if (wb_valid && wb_addr == r) return wb_data;
        return rf[r];
    endfunction

    task automatic set_in(bit v, logic [31:0] i, logic [31:0] pc);
        in_valid = v;
        in_instr = i;
        in_pc    = pc;
    endtask

    task automatic set_wb(bit v, logic [4:0] a, logic [31:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    // One clock: predict from pre-edge inputs, then advance the model.
    task automatic tick(output bit acc);
        logic [31:0] i;
        logic [31:0] o1, o2;
        bit hz;
        i   = in_instr;
        hz  = m_hazard(i);
        acc = !rst && in_valid && m_ready(i);
        o1  = src_val(reads1(i), i[19:15]);
        o2  = src_val(reads2(i), i[24:20]);
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (pend[k]) pend[k] = 1'b0;
            m_valid = 0; m_instr = '0; m_pc = '0;
            m_op1 = '0; m_op2 = '0; m_rd = '0; m_wr = 0;
            m_stall = '0;
        end else begin
            if (in_valid && hz && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 1;
            if (wb_valid && wb_addr != 5'd0) begin
                pend[wb_addr] = 1'b0;
                rf[wb_addr]   = wb_data;
            end
            if (acc) begin
                if (dest(i)) pend[i[11:7]] = 1'b1;
                m_valid = 1; m_instr = i; m_pc = in_pc;
                m_op1 = o1; m_op2 = o2; m_rd = i[11:7]; m_wr = dest(i);
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tk();
        bit a;
        tick(a);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        set_wb(0, 0, 0);
        set_in(1, 32'h006283B3, 32'h0);
        tk();
        tk();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 32'd0) begin n_err++;
            $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        n_cmp++; if (out_op1 !== 32'd0 || out_wr !== 1'b0) begin n_err++;
            $display("FAIL reset_data got op1=%h wr=%0b want 0/0", out_op1, out_wr); end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_ready got %0b want 1", in_ready); end
        tk();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_no_accept got %0b want 0", out_valid); end
    endtask

    task automatic test_basic_issue();
        set_wb(1, 5, 32'h11);
        tk();
        set_wb(1, 6, 32'h22);
        tk();
        set_wb(0, 0, 0);
        set_in(1, 32'h006283B3, 32'h100);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL basic_ready got %0b want 1", in_ready); end
        n_cmp++; if (addr_1 !== 5'd5 || addr_2 !== 5'd6) begin n_err++;
            $display("FAIL basic_addr got %0d/%0d want 5/6", addr_1, addr_2); end
        tk();
        in_valid = 1'b0;
        n_cmp++; if (out_op1 !== 32'h11 || out_op2 !== 32'h22) begin n_err++;
            $display("FAIL basic_ops got %h/%h want 11/22", out_op1, out_op2); end
        n_cmp++; if (out_rd !== 5'd7 || out_wr !== 1'b1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_rd got rd=%0d wr=%0b v=%0b want 7/1/1",
                     out_rd, out_wr, out_valid); end
        n_cmp++; if (out_pc !== 32'h100) begin n_err++;
            $display("FAIL basic_pc got %h want 100", out_pc); end
    endtask

    task automatic test_raw_bypass();
        set_in(1, 32'h00138413, 32'h104);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL raw_block got %0b want 0", in_ready); end
        for (int k = 1; k <= 3; k++) begin
            tk();
            n_cmp++; if (stall_cnt !== 32'(k)) begin n_err++;
                $display("FAIL raw_stall got %0d want %0d", stall_cnt, k); end
        end
        set_wb(1, 7, 32'hDEAD);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL raw_release got %0b want 1", in_ready); end
        tk();
        set_wb(0, 0, 0);
        in_valid = 1'b0;
        n_cmp++; if (out_op1 !== 32'hDEAD || out_rd !== 5'd8) begin n_err++;
            $display("FAIL raw_bypass got op1=%h rd=%0d want dead/8", out_op1, out_rd); end
        n_cmp++; if (stall_cnt !== 32'd3) begin n_err++;
            $display("FAIL raw_stall_hold got %0d want 3", stall_cnt); end
        in_instr = 32'h000385B3;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL raw_x7_free got %0b want 1", in_ready); end
        in_instr = 32'h00040613;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL raw_x8_busy got %0b want 0", in_ready); end
    endtask

    task automatic test_waw_x0();
        set_wb(1, 8, 32'h88);
        set_in(1, 32'h00500013, 32'h108);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL x0_ready got %0b want 1", in_ready); end
        tk();
        set_wb(0, 0, 0);
        n_cmp++; if (out_wr !== 1'b0 || out_op1 !== 32'd0 || out_rd !== 5'd0) begin
            n_err++;
            $display("FAIL x0_issue got wr=%0b op1=%h rd=%0d want 0/0/0",
                     out_wr, out_op1, out_rd); end
        set_in(1, 32'h123454B7, 32'h10C);
        tk();
        set_in(1, 32'h000014B7, 32'h110);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL waw_block got %0b want 0", in_ready); end
        tk();
        n_cmp++; if (stall_cnt !== 32'd4) begin n_err++;
            $display("FAIL waw_stall got %0d want 4", stall_cnt); end
        set_wb(1, 9, 32'h99);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL waw_release got %0b want 1", in_ready); end
        tk();
        set_wb(0, 0, 0);
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== 32'h000014B7 || out_rd !== 5'd9 || out_wr !== 1'b1) begin
            n_err++;
            $display("FAIL waw_issue got %h rd=%0d wr=%0b want 000014b7/9/1",
                     out_instr, out_rd, out_wr); end
        set_wb(1, 9, 32'h999);
        tk();
        set_wb(0, 0, 0);
    endtask

    task automatic test_backpressure();
        logic [31:0] s0;
        set_in(1, 32'h00308693, 32'h114);
        tk();
        out_ready = 1'b0;
        set_in(1, 32'h00410713, 32'h118);
        s0 = m_stall;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++;
                $display("FAIL bp_ready got %0b want 0", in_ready); end
            tk();
            n_cmp++; if (out_instr !== 32'h00308693 || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold got %h v=%0b want 00308693/1",
                         out_instr, out_valid); end
            n_cmp++; if (stall_cnt !== s0) begin n_err++;
                $display("FAIL bp_stall got %0d want %0d", stall_cnt, s0); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL bp_release got %0b want 1", in_ready); end
        tk();
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== 32'h00410713 || out_pc !== 32'h118) begin n_err++;
            $display("FAIL bp_issue got %h pc=%h want 00410713/118", out_instr, out_pc); end
    endtask

    task automatic test_same_cycle();
        set_in(1, 32'h00AAA537, 32'h11C);
        tk();
        set_in(1, 32'h00150513, 32'h120);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL sc_block got %0b want 0", in_ready); end
        set_wb(1, 10, 32'h5555);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL sc_release got %0b want 1", in_ready); end
        tk();
        set_wb(0, 0, 0);
        in_valid = 1'b0;
        n_cmp++; if (out_op1 !== 32'h5555 || out_rd !== 5'd10 || out_wr !== 1'b1) begin
            n_err++;
            $display("FAIL sc_issue got op1=%h rd=%0d wr=%0b want 5555/10/1",
                     out_op1, out_rd, out_wr); end
        in_instr = 32'h00050793;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL sc_still_busy got %0b want 0", in_ready); end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};
        return {7'($urandom), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 3'($urandom),
                5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
    endfunction

    task automatic test_random();
        bit acc;
        logic [4:0] q [$];
        rst = 1'b1;
        set_wb(0, 0, 0);
        in_valid = 1'b0;
        tk();
        rst = 1'b0;
        set_in(0, rand_instr(), 32'h1000);
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            q.delete();
            for (int r = 1; r < 32; r++) if (pend[r]) q.push_back(5'(r));
            if (q.size() != 0 && $urandom_range(0, 9) < 4)
                set_wb(1, q[$urandom_range(0, q.size() - 1)], $urandom);
            else
                set_wb(0, 5'($urandom), $urandom);
            #1;
            n_cmp++; if (in_ready !== m_ready(in_instr)) begin n_err++;
                $display("FAIL rnd_ready cyc %0d got %0b want %0b",
                         c, in_ready, m_ready(in_instr)); end
            n_cmp++; if (addr_1 !== in_instr[19:15] || addr_2 !== in_instr[24:20]) begin
                n_err++;
                $display("FAIL rnd_addr cyc %0d got %0d/%0d", c, addr_1, addr_2); end
            tick(acc);
            n_cmp++;
            if (out_valid !== m_valid || stall_cnt !== m_stall) begin
                n_err++;
                $display("FAIL rnd_ctl cyc %0d got v=%0b st=%0d want v=%0b st=%0d",
                         c, out_valid, stall_cnt, m_valid, m_stall);
            end
            n_cmp++;
            if (out_instr !== m_instr || out_pc !== m_pc || out_op1 !== m_op1
                || out_op2 !== m_op2 || out_rd !== m_rd || out_wr !== m_wr) begin
                n_err++;
                $display("FAIL rnd_data cyc %0d got %h %h %h %h %0d %0b want %h %h %h %h %0d %0b",
                         c, out_instr, out_pc, out_op1, out_op2, out_rd, out_wr,
                         m_instr, m_pc, m_op1, m_op2, m_rd, m_wr);
            end
            if (acc) set_in(in_valid, rand_instr(), in_pc + 32'd4);
        end
        set_wb(0, 0, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        foreach (rf[k]) rf[k] = 32'd0;
        foreach (pend[k]) pend[k] = 1'b0;
        m_valid = 0; m_instr = '0; m_pc = '0; m_op1 = '0;
        m_op2 = '0; m_rd = '0; m_wr = 0; m_stall = '0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc = '0;
        out_ready = 1'b1;
        set_wb(0, 0, 0);
        test_reset();
        test_basic_issue();
        test_raw_bypass();
        test_waw_x0();
        test_backpressure();
        test_same_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch stage that sits directly upstream of `reg_file`. It accepts one RV32I instruction per cycle over a valid/ready handshake and drives the register-file read addresses `addr_1` and `addr_2`. It captures `rd_1` and `rd_2` with write-back bypass, and blocks issue on RAW/WAW hazards using a per-register busy scoreboard. Its output is a one-entry pipeline register that feeds the execute stage.

## Interface
- `ADW`, 5, register address width; 2**ADW architectural registers.
- `DPW`, 32, data / instruction / PC width.
- `clk` input 1, single clock; all state updates on rising edge.
- `rst` input 1, synchronous, active-high reset.
- `in_valid` input 1, upstream instruction valid.
- `in_ready` output 1, stage can accept this cycle.
- `in_instr` input DPW, RV32I instruction word.
- `in_pc` input DPW, instruction PC.
- `addr_1` output ADW, to `reg_file`; combinational `in_instr[19:15]` (rs1).
- `addr_2` output ADW, to `reg_file`; combinational `in_instr[24:20]` (rs2).
- `rd_1` input DPW, `reg_file` combinational read data for `addr_1`.
- `rd_2` input DPW, `reg_file` combinational read data for `addr_2`.
- `wb_valid` input 1, write-back event; the same signal drives `reg_file.we_3`.
- `wb_addr` input ADW, write-back register; the same signal drives `addr_3`.
- `wb_data` input DPW, write-back data; the same signal drives `wd_3`.
- `out_valid` output 1, issued instruction valid.
- `out_ready` input 1, downstream accepts.
- `out_instr`, `out_pc`, `out_op1`, `out_op2` output DPW each; the registered instruction, PC and operands.
- `out_rd` output ADW, destination register.
- `out_wr` output 1, instruction writes `out_rd`.
- `stall_cnt` output 32, saturating count of hazard-stall cycles.

## Operation
- **Decode** from `opcode = in_instr[6:0]`:
  - uses_rs1: every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - uses_rs2: only R-type 0110011, STORE 0100011 and BRANCH 1100011.
  - writes_rd: every opcode except STORE and BRANCH, and only when rd = `in_instr[11:7]` is nonzero.
- **Scoreboard**: `busy[2**ADW-1:0]`. `busy[0]` is always 0.
  - Set: `busy[rd]` is set on accept when writes_rd.
  - Clear: `busy[wb_addr]` is cleared when `wb_valid` is high.
  - Same-cycle set and clear of the same index: the set wins, because the new write is still pending.
- **Effective busy** for a source register is `busy[r] & ~(wb_valid & wb_addr==r)`. A write-back in the current cycle resolves the hazard.
- **Hazard** = (uses_rs1 & effbusy(rs1)) | (uses_rs2 & effbusy(rs2)) | (writes_rd & effbusy(rd)). The last term covers WAW.
- **Handshake**:
  - `in_ready = (~out_valid | out_ready) & ~hazard`.
  - Accept = `in_valid & in_ready`.
  - `in_ready` may depend combinationally on `in_instr` and `wb_*`. Upstream must hold `in_instr` while `in_valid` is high and the instruction is not accepted.
- **Operand select**, per source, in priority order:
  - Register index 0, or the source is unused: 0.
  - `wb_valid & wb_addr==r`: `wb_data`.
  - Otherwise: `rd_1` or `rd_2`.
- **Output register**:
  - On accept, load `out_*` and set `out_valid`.
  - Else if `out_ready`, clear `out_valid`.
  - Else hold all `out_*` unchanged.
- **stall_cnt**: increments each cycle where `in_valid & hazard`, and saturates at 0xFFFF_FFFF.

## Timing
- Reset (`rst` high at a rising edge): `out_valid`=0; `out_*` data=0; `out_wr`=0; `busy`=all 0; `stall_cnt`=0. Reset overrides any accept or write-back in the same cycle.
- `addr_1`/`addr_2` and `in_ready` are combinational and valid in the same cycle as `in_instr`.
- Latency: an instruction accepted at edge N is visible on `out_*` after edge N, i.e. 1 cycle.
- Throughput: 1 instruction/cycle with no hazards and `out_ready` high.
- Back-pressure: if `out_ready` is low while `out_valid` is high, `in_ready`=0 and `out_*` is stable.
- Write-back at edge N clears the hazard in the same cycle. An instruction blocked only by that register is accepted at edge N with `wb_data` as its operand.
- Scoreboard width is 2**ADW. `wb_addr`=0 has no effect.

## Test plan
- **Reset**: hold `rst` 2 cycles with `in_valid`=1 → `out_valid`=0, `stall_cnt`=0, `in_ready`=1 the cycle after reset releases, no accept during reset.
- **Basic issue**: x5=0x11, x6=0x22 preloaded via `wb_*`; issue `add x7,x5,x6` (0x006283B3) at PC 0x100 → next cycle `out_op1`=0x11, `out_op2`=0x22, `out_rd`=7, `out_wr`=1, `busy[7]`=1.
- **RAW stall then bypass**: issue `add x7,...` then `addi x8,x7,1` → `in_ready`=0 and `stall_cnt` increments each cycle. Then drive `wb_valid`=1, `wb_addr`=7, `wb_data`=0xDEAD → the same-cycle accept has `out_op1`=0xDEAD, and `busy[7]`=0 then `busy[8]`=1.
- **WAW and x0**: `addi x0,x0,5` → `out_wr`=0, `out_op1`=0, no busy set. Two back-to-back writes to x9 → the second stalls until x9 write-back.
- **Back-pressure**: `out_ready`=0 for 3 cycles with a new instruction pending → `out_*` unchanged, `in_ready`=0, `stall_cnt` unchanged. When `out_ready`=1, the pending instruction issues the next cycle.
- **Same-cycle set/clear**: x10 busy; write-back of x10 in the same cycle that `addi x10,x10,1` is accepted → the operand is `wb_data` and `busy[10]` remains 1.
